// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer commit queue: retirement payload and
// write-type encoding used by dispatch, writeback and commit.
package rob_pkg;

  localparam int PC_W    = 32;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int REGID_W = 5;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    REG  = 2'd1,
    MEM  = 2'd2,
    OUT  = 2'd3
  } rob_write_t;

  typedef struct packed {
    logic               end_flag;
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  addr;
    logic [REGID_W-1:0] regid;
    rob_write_t         wtype;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// Retirement window scan: lane i may retire only if every entry from head up
// to it is allocated and done, and no older lane in the window is an end marker.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int COMMIT_WIDTH = 2,
  localparam int IDW         = $clog2(DEPTH)
) (
  input  logic [IDW-1:0]          head,
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH-1:0]        done,
  input  logic [DEPTH-1:0]        end_flag,
  input  logic                    halted,
  output logic [COMMIT_WIDTH-1:0] commit_valid
);

  logic [COMMIT_WIDTH-1:0][IDW-1:0] lane_idx;
  logic                             run;

  always_comb begin
    commit_valid = '0;
    lane_idx     = '0;
    run          = !halted;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_idx[i]     = head + IDW'(i);
      run             = run && valid[lane_idx[i]] && done[lane_idx[i]];
      commit_valid[i] = run;
      // an end marker retires itself but closes the window behind it
      run             = run && !end_flag[lane_idx[i]];
    end
  end

endmodule

// File: rtl/rob_commit_queue.sv
// Circular reorder buffer: in-order allocation at tail, out-of-order completion
// by id, in-order multi-lane retirement at head with a sticky halt on end_flag.
module rob_commit_queue
  import rob_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int DISPATCH_WIDTH = 2,
  parameter int WB_PORTS       = 2,
  parameter int COMMIT_WIDTH   = 2,
  localparam int IDW           = $clog2(DEPTH)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [DISPATCH_WIDTH-1:0]           alloc_valid,
  output logic                                alloc_ready,
  output logic [DISPATCH_WIDTH-1:0][IDW-1:0]  alloc_id,
  input  logic [WB_PORTS-1:0]                 wb_valid,
  input  logic [WB_PORTS-1:0][IDW-1:0]        wb_id,
  input  rob_entry_t [WB_PORTS-1:0]           wb_data,
  input  logic                                commit_ready,
  output logic [COMMIT_WIDTH-1:0]             commit_valid,
  output rob_entry_t [COMMIT_WIDTH-1:0]       commit_entry,
  input  logic                                flush,
  output logic [IDW:0]                        count,
  output logic                                halted
);

  logic [IDW-1:0]   head_q;
  logic [IDW-1:0]   tail_q;
  logic [IDW:0]     count_q;
  logic             halted_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  rob_entry_t       mem_q [DEPTH];

  logic [IDW:0]     free_slots;
  logic [IDW:0]     n_alloc;
  logic [IDW:0]     n_commit;
  logic [DEPTH-1:0] alloc_mask;
  logic [DEPTH-1:0] wb_mask;
  logic [DEPTH-1:0] commit_mask;
  logic [DEPTH-1:0] end_vec;
  logic             retire_end;
  logic [COMMIT_WIDTH-1:0][IDW-1:0] commit_idx;

  // Allocation decision uses only the registered occupancy.
  always_comb begin
    free_slots  = (IDW+1)'(DEPTH) - count_q;
    alloc_ready = free_slots >= (IDW+1)'(DISPATCH_WIDTH);
    alloc_mask  = '0;
    n_alloc     = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      alloc_id[i] = tail_q + IDW'(i);
      if (alloc_ready && alloc_valid[i]) begin
        alloc_mask[alloc_id[i]] = 1'b1;
        n_alloc                 = n_alloc + (IDW+1)'(1);
      end
    end
  end

  always_comb begin
    wb_mask = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && valid_q[wb_id[p]]) wb_mask[wb_id[p]] = 1'b1;
    end
  end

  always_comb begin
    end_vec = '0;
    for (int j = 0; j < DEPTH; j++) end_vec[j] = mem_q[j].end_flag;
  end

  rob_commit_select #(
    .DEPTH        (DEPTH),
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_select (
    .head         (head_q),
    .valid        (valid_q),
    .done         (done_q),
    .end_flag     (end_vec),
    .halted       (halted_q),
    .commit_valid (commit_valid)
  );

  always_comb begin
    commit_mask  = '0;
    n_commit     = '0;
    retire_end   = 1'b0;
    commit_idx   = '0;
    commit_entry = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_idx[i]   = head_q + IDW'(i);
      commit_entry[i] = mem_q[commit_idx[i]];
      if (commit_ready && commit_valid[i]) begin
        commit_mask[commit_idx[i]] = 1'b1;
        n_commit                   = n_commit + (IDW+1)'(1);
        if (mem_q[commit_idx[i]].end_flag) retire_end = 1'b1;
      end
    end
  end

  // Control state: pointers, occupancy, per-entry valid/done, halt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      done_q   <= '0;
      halted_q <= 1'b0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      tail_q  <= tail_q + IDW'(n_alloc);
      head_q  <= head_q + IDW'(n_commit);
      count_q <= count_q + n_alloc - n_commit;
      valid_q <= (valid_q & ~commit_mask) | alloc_mask;
      done_q  <= (done_q | wb_mask) & ~commit_mask & ~alloc_mask;
      if (retire_end) halted_q <= 1'b1;
    end
  end

  // Payload storage has no reset; a later port overwrites an earlier one.
  always_ff @(posedge clock) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && valid_q[wb_id[p]]) mem_q[wb_id[p]] <= wb_data[p];
    end
  end

  assign count  = count_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench for rob_commit_queue with a program-order queue model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_rob_commit_queue;
  import rob_pkg::*;

  localparam int DEPTH = 32;
  localparam int DW    = 2;
  localparam int WBP   = 2;
  localparam int CW    = 2;
  localparam int IDW   = 5;

  logic                        clock = 1'b0;
  logic                        reset_n = 1'b0;
  logic [DW-1:0]               alloc_valid;
  logic                        alloc_ready;
  logic [DW-1:0][IDW-1:0]      alloc_id;
  logic [WBP-1:0]              wb_valid;
  logic [WBP-1:0][IDW-1:0]     wb_id;
  rob_entry_t [WBP-1:0]        wb_data;
  logic                        commit_ready;
  logic [CW-1:0]               commit_valid;
  rob_entry_t [CW-1:0]         commit_entry;
  logic                        flush;
  logic [IDW:0]                count;
  logic                        halted;

  int n_checks = 0;
  int n_err    = 0;

  rob_commit_queue #(
    .DEPTH(DEPTH), .DISPATCH_WIDTH(DW), .WB_PORTS(WBP), .COMMIT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_entry(commit_entry),
    .flush(flush), .count(count), .halted(halted)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_e(input string name, input rob_entry_t act, input rob_entry_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rob_entry_t mk(input int id, input bit endf, input int salt);
    rob_entry_t e;
    e.end_flag = endf;
    e.pc       = 32'h1000 + 32'(id) * 4;
    e.data     = 32'hA000_0000 ^ 32'(id * 37 + salt);
    e.addr     = 32'h8000_0000 + 32'(id);
    e.regid    = 5'(id + salt);
    e.wtype    = rob_write_t'(2'(id));
    return e;
  endfunction

  // Model: entries held as a queue of ids in program order.
  int         mq[$];
  bit         m_inq  [DEPTH];
  bit         m_done [DEPTH];
  rob_entry_t m_data [DEPTH];
  int         m_next;
  bit         m_halt;

  function automatic int m_commit_n();
    int k = 0;
    if (m_halt) return 0;
    while (k < CW && k < mq.size() && m_done[mq[k]] &&
           (k == 0 || !m_data[mq[k-1]].end_flag)) k++;
    return k;
  endfunction

  task automatic m_reset();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_inq[i]  = 1'b0;
      m_done[i] = 1'b0;
    end
    m_next = 0;
    m_halt = 1'b0;
  endtask

  task automatic m_step();
    int k;
    int id;
    bit rdy;
    bit endhit;
    k      = m_commit_n();
    rdy    = (DEPTH - mq.size()) >= DW;
    endhit = 1'b0;
    for (int i = 0; i < k; i++) if (m_data[mq[i]].end_flag) endhit = 1'b1;
    if (flush) begin
      mq.delete();
      for (int i = 0; i < DEPTH; i++) begin
        m_inq[i]  = 1'b0;
        m_done[i] = 1'b0;
      end
      m_next = 0;
    end else begin
      for (int p = 0; p < WBP; p++) begin
        if (wb_valid[p] && m_inq[wb_id[p]]) begin
          m_data[wb_id[p]] = wb_data[p];
          m_done[wb_id[p]] = 1'b1;
        end
      end
      if (commit_ready) begin
        for (int i = 0; i < k; i++) begin
          id = mq.pop_front();
          m_inq[id]  = 1'b0;
          m_done[id] = 1'b0;
        end
        if (endhit) m_halt = 1'b1;
      end
      if (rdy) begin
        for (int i = 0; i < DW; i++) begin
          if (alloc_valid[i]) begin
            mq.push_back(m_next);
            m_inq[m_next]  = 1'b1;
            m_done[m_next] = 1'b0;
            m_next = (m_next + 1) % DEPTH;
          end
        end
      end
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  always @(negedge clock) begin : cmp
    int k;
    if (reset_n) begin
      k = m_commit_n();
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_alloc_ready", 64'(alloc_ready), 64'((DEPTH - mq.size()) >= DW));
      for (int i = 0; i < DW; i++)
        chk("m_alloc_id", 64'(alloc_id[i]), 64'((m_next + i) % DEPTH));
      chk("m_commit_valid", 64'(commit_valid), 64'((1 << k) - 1));
      chk("m_halted", 64'(halted), 64'(m_halt));
      for (int i = 0; i < k; i++)
        chk_e("m_commit_entry", commit_entry[i], m_data[mq[i]]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    alloc_valid = '0;
    wb_valid    = '0;
    flush       = 1'b0;
  endtask

  task automatic wb1(input int p, input int id, input rob_entry_t e);
    wb_valid[p] = 1'b1;
    wb_id[p]    = IDW'(id);
    wb_data[p]  = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    alloc_valid  = '0;
    wb_valid     = '0;
    wb_id        = '0;
    wb_data      = '0;
    commit_ready = 1'b1;
    flush        = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_alloc_id0", 64'(alloc_id[0]), 64'd0);
    chk("rst_alloc_id1", 64'(alloc_id[1]), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    reset_n = 1'b1;

    // Fill: two per cycle up to full
    for (int c = 0; c < 16; c++) begin
      chk("fill_id0", 64'(alloc_id[0]), 64'(2 * c));
      chk("fill_id1", 64'(alloc_id[1]), 64'(2 * c + 1));
      alloc_valid = 2'b11;
      tick();
    end
    chk("full_count", 64'(count), 64'd32);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    alloc_valid = 2'b11;
    tick();
    chk("full_ignored_count", 64'(count), 64'd32);
    chk("full_tail_wrap", 64'(alloc_id[0]), 64'd0);

    // Out-of-order completion: id 1 then id 0, with commit stalled
    wb1(0, 1, mk(1, 1'b0, 0));
    tick();
    chk("ooo_wait0", 64'(commit_valid), 64'd0);
    tick();
    chk("ooo_wait1", 64'(commit_valid), 64'd0);
    commit_ready = 1'b0;
    wb1(0, 0, mk(0, 1'b0, 0));
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 64'(commit_valid), 64'd3);
      chk_e("stall_entry0", commit_entry[0], mk(0, 1'b0, 0));
      chk_e("stall_entry1", commit_entry[1], mk(1, 1'b0, 0));
      chk("stall_count", 64'(count), 64'd32);
      tick();
    end
    commit_ready = 1'b1;
    tick();
    chk("release_count", 64'(count), 64'd30);
    chk("release_valid", 64'(commit_valid), 64'd0);

    // Drain 2..29 so head reaches 30, then exercise wrap
    for (int id = 2; id < 30; id += 2) begin
      wb1(0, id, mk(id, 1'b0, 0));
      wb1(1, id + 1, mk(id + 1, 1'b0, 0));
      tick();
    end
    tick();
    tick();
    chk("drain_count", 64'(count), 64'd2);
    chk("drain_ready", 64'(alloc_ready), 64'd1);
    chk("wrap_alloc_id0", 64'(alloc_id[0]), 64'd0);
    alloc_valid = 2'b01;
    tick();
    chk("wrap_count", 64'(count), 64'd3);
    commit_ready = 1'b0;
    wb1(0, 31, mk(31, 1'b0, 0));
    wb1(1, 0, mk(0, 1'b0, 5));
    tick();
    wb1(0, 30, mk(30, 1'b0, 0));
    tick();
    chk("wrap_valid_a", 64'(commit_valid), 64'd3);
    chk_e("wrap_entry30", commit_entry[0], mk(30, 1'b0, 0));
    chk_e("wrap_entry31", commit_entry[1], mk(31, 1'b0, 0));
    commit_ready = 1'b1;
    tick();
    chk("wrap_valid_b", 64'(commit_valid), 64'd1);
    chk_e("wrap_entry0", commit_entry[0], mk(0, 1'b0, 5));
    chk("wrap_count_b", 64'(count), 64'd1);
    tick();
    chk("wrap_empty", 64'(count), 64'd0);

    // end_flag on id 5 with id 6 already done; duplicate writeback on id 2
    flush = 1'b1;
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_id0", 64'(alloc_id[0]), 64'd0);
    for (int c = 0; c < 4; c++) begin
      alloc_valid = 2'b11;
      tick();
    end
    chk("end_count8", 64'(count), 64'd8);
    wb1(0, 0, mk(0, 1'b0, 0));
    wb1(1, 1, mk(1, 1'b0, 0));
    tick();
    chk("end_v01", 64'(commit_valid), 64'd3);
    wb1(0, 2, mk(2, 1'b0, 1));
    wb1(1, 2, mk(2, 1'b0, 2));
    tick();
    chk("dup_valid", 64'(commit_valid), 64'd1);
    chk_e("dup_port1_wins", commit_entry[0], mk(2, 1'b0, 2));
    wb1(0, 3, mk(3, 1'b0, 0));
    wb1(1, 4, mk(4, 1'b0, 0));
    tick();
    chk("end_v34", 64'(commit_valid), 64'd3);
    wb1(0, 6, mk(6, 1'b0, 0));
    tick();
    chk("end_wait5", 64'(commit_valid), 64'd0);
    wb1(0, 5, mk(5, 1'b1, 0));
    tick();
    chk("end_only5", 64'(commit_valid), 64'd1);
    chk("end_flag5", 64'(commit_entry[0].end_flag), 64'd1);
    tick();
    chk("end_halted", 64'(halted), 64'd1);
    chk("end_blocked", 64'(commit_valid), 64'd0);
    chk("end_count2", 64'(count), 64'd2);
    repeat (3) tick();
    chk("end_still_blocked", 64'(commit_valid), 64'd0);
    chk("end_still_count", 64'(count), 64'd2);

    // Flush beats same-cycle alloc and writeback; halted survives flush
    alloc_valid = 2'b11;
    wb1(0, 7, mk(7, 1'b0, 0));
    flush = 1'b1;
    tick();
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_id0", 64'(alloc_id[0]), 64'd0);
    chk("fl_halted", 64'(halted), 64'd1);
    alloc_valid = 2'b11;
    tick();
    wb1(0, 0, mk(0, 1'b0, 0));
    wb1(1, 1, mk(1, 1'b0, 0));
    tick();
    chk("fl_halt_blocks", 64'(commit_valid), 64'd0);
    alloc_valid = 2'b11;
    tick();
    chk("pre_rst_count", 64'(count), 64'd4);

    // Asynchronous reset in mid-cycle drops everything
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_halted", 64'(halted), 64'd0);
    chk("arst_valid", 64'(commit_valid), 64'd0);
    chk("arst_id0", 64'(alloc_id[0]), 64'd0);
    chk("arst_ready", 64'(alloc_ready), 64'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    alloc_valid = 2'b11;
    tick();
    wb1(0, 0, mk(0, 1'b0, 9));
    wb1(1, 1, mk(1, 1'b0, 9));
    tick();
    chk("post_rst_valid", 64'(commit_valid), 64'd3);
    tick();
    chk("post_rst_count", 64'(count), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/rob_commit_queue.md
ROB_COMMIT_QUEUE -- requirements
Module: rob_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of entries, a power of two, at least 4.
REQ-002 SHALL have parameter DISPATCH_WIDTH, default 2: allocation lanes per cycle.
REQ-003 SHALL have parameter WB_PORTS, default 2: completion write ports.
REQ-004 SHALL have parameter COMMIT_WIDTH, default 2: maximum retirements per cycle.
REQ-005 SHALL have port clock, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port alloc_valid, input, DISPATCH_WIDTH: per-lane allocation request, set bits contiguous from lane 0.
REQ-008 SHALL have port alloc_ready, output, 1: high when free entries >= DISPATCH_WIDTH.
REQ-009 SHALL have port alloc_id, output, DISPATCH_WIDTH x IDW: entry id for each lane, where IDW = clog2(DEPTH).
REQ-010 SHALL have port wb_valid, input, WB_PORTS: completion strobe per port.
REQ-011 SHALL have port wb_id, input, WB_PORTS x IDW: target entry id per port.
REQ-012 SHALL have port wb_data, input, WB_PORTS x rob_entry_t: payload {end_flag, pc, data, addr, regid, wtype}.
REQ-013 SHALL have port commit_ready, input, 1: retirement consumer accepts this cycle.
REQ-014 SHALL have port commit_valid, output, COMMIT_WIDTH: retiring lanes, contiguous from lane 0.
REQ-015 SHALL have port commit_entry, output, COMMIT_WIDTH x rob_entry_t: retiring payloads in program order.
REQ-016 SHALL have port flush, input, 1: discard all entries.
REQ-017 SHALL have port count, output, IDW+1: number of occupied entries.
REQ-018 SHALL have port halted, output, 1: an end_flag entry has retired.

Function
REQ-019 SHALL compute alloc_id[i] = tail+i modulo DEPTH, wrapping.
REQ-020 SHALL, on a clock edge with alloc_ready high, mark the requested entries allocated and not done, and advance tail by popcount(alloc_valid).
REQ-021 SHALL ignore alloc_valid while alloc_ready is low.
REQ-022 SHALL derive alloc_ready from registered count only; same-cycle commits do not free entries for allocation.
REQ-023 SHALL, for wb_valid[p] targeting an allocated entry, store the payload and set done at the edge; completion is visible to commit one cycle later.
REQ-024 SHALL ignore writebacks to unallocated ids.
REQ-025 SHALL resolve a duplicate wb_id in the same cycle in favour of the higher port index.
REQ-026 SHALL drive commit_valid[i] combinationally high iff entries head..head+i are all allocated and done, none of entries head..head+i-1 has end_flag, and halted is low.
REQ-027 SHALL, when commit_ready is high, deallocate the lanes with commit_valid set and advance head by popcount(commit_valid) at the edge.
REQ-028 SHALL hold head and entry state while commit_ready is low, leaving outputs stable.
REQ-029 SHALL set halted, sticky, when an entry with end_flag retires, and then block further commits.
REQ-030 SHALL update count as count + allocated - retired each cycle, with count = DEPTH meaning full and count = 0 meaning empty.
REQ-031 SHALL give flush priority over same-cycle alloc, writeback and commit: head = tail = 0, all entries invalid, halted unchanged.

Reset
REQ-032 SHALL, while reset_n is low, asynchronously force head = 0, tail = 0, count = 0, all valid and done bits = 0, and halted = 0; resulting outputs are alloc_ready = 1, commit_valid = 0, alloc_id[i] = i.
REQ-033 SHALL leave payload storage uncleared by reset.
REQ-034 SHALL, on reset asserted mid-operation, drop all in-flight entries without retiring them.

Structure
REQ-035 SHALL place rob_entry_t and rob_write_t (NONE, REG, MEM, OUT) in shared package rob_pkg.
REQ-036 SHALL implement the contiguous-done and end_flag scan in sub-module rob_commit_select, which outputs commit_valid.

Verification
REQ-037 SHALL cover: allocate 2 per cycle, 16 cycles -> ids 0..31, count = 32, alloc_ready = 0 at full.
REQ-038 SHALL cover: writebacks to ids 1 then 0 -> nothing retires until id 0 is done, then ids 0 and 1 retire in one cycle.
REQ-039 SHALL cover: head = 30 with entries 30, 31, 0 done -> ids 30 and 31 retire, then id 0 retires; wrap is correct.
REQ-040 SHALL cover: end_flag on id 5 with id 6 done -> id 5 retires, halted = 1, id 6 never retires.
REQ-041 SHALL cover: flush asserted with alloc and wb in the same cycle -> count = 0, alloc_id[0] = 0 on the next cycle.
REQ-042 SHALL cover: commit_ready held low for 3 cycles -> commit_entry stable, and retirement occurs on release.
